// File: rtl/spi_flash_responder.sv
// -----------------------------------------------------------------------------
// spi_flash_responder
//
// Emulates a single-lane SPI NOR flash target in the fabric. It answers READ
// (0x03), READ STATUS (0x05) and JEDEC ID (0x9F). READ data comes from a
// byte-wide synchronous memory port. clk_gen oversamples csb, sck and mosi, so
// the block has no SPI clock domain. clk_gen must run at least 8x the sck rate.
//
// Ports
//   clk_gen        system clock (>= 8x sck)
//   rst_n          asynchronous active-low reset
//   spi_csb_i      chip select from the master, active-low
//   spi_sck_i      SPI clock, mode 0
//   spi_mosi_i     serial data from the master (sd0)
//   spi_miso_o     serial data to the master (sd1)
//   spi_miso_oe_o  MISO pad drive enable
//   mem_req_o      one-cycle read strobe to the backing memory
//   mem_addr_o     byte address presented with mem_req_o
//   mem_rdata_i    read data, valid one cycle after mem_req_o
//   busy_o         high while the synchronised csb is low
//   read_cnt_o     count of completed READ transactions (wraps)
//
// ADDR_W must lie in 8..24. The address shifter keeps only the low ADDR_W
// bits of the 24-bit flash address, which also gives the truncation.
// -----------------------------------------------------------------------------
module spi_flash_responder #(
  parameter int          ADDR_W     = 16,
  parameter logic [7:0]  STATUS_VAL = 8'h00,
  parameter logic [23:0] JEDEC_ID   = 24'hEF4018
) (
  input  logic              clk_gen,
  input  logic              rst_n,
  input  logic              spi_csb_i,
  input  logic              spi_sck_i,
  input  logic              spi_mosi_i,
  output logic              spi_miso_o,
  output logic              spi_miso_oe_o,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic [7:0]        mem_rdata_i,
  output logic              busy_o,
  output logic [15:0]       read_cnt_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_ADDR,
    S_DATA,
    S_STATUS,
    S_ID,
    S_IGNORE
  } state_e;

  localparam logic [7:0] CMD_READ   = 8'h03;
  localparam logic [7:0] CMD_STATUS = 8'h05;
  localparam logic [7:0] CMD_ID     = 8'h9F;

  // ---------------------------------------------------------------------------
  // Input synchronisers and edge detection
  // ---------------------------------------------------------------------------
  logic csb_meta_q, csb_sync_q, csb_prev_q;
  logic sck_meta_q, sck_sync_q, sck_prev_q;
  logic mosi_meta_q, mosi_sync_q;

  // NOTE: sequential state uses non-blocking assignments only. Every flop then
  // samples the pre-edge values, and the synchroniser chain shifts by exactly
  // one stage per clock instead of collapsing into a single flop.
  always_ff @(posedge clk_gen or negedge rst_n) begin
    if (!rst_n) begin
      // csb resets to deasserted, so a fresh falling edge is needed after reset.
      csb_meta_q  <= 1'b1;
      csb_sync_q  <= 1'b1;
      csb_prev_q  <= 1'b1;
      sck_meta_q  <= 1'b0;
      sck_sync_q  <= 1'b0;
      sck_prev_q  <= 1'b0;
      mosi_meta_q <= 1'b0;
      mosi_sync_q <= 1'b0;
    end else begin
      csb_meta_q  <= spi_csb_i;
      csb_sync_q  <= csb_meta_q;
      csb_prev_q  <= csb_sync_q;
      sck_meta_q  <= spi_sck_i;
      sck_sync_q  <= sck_meta_q;
      sck_prev_q  <= sck_sync_q;
      mosi_meta_q <= spi_mosi_i;
      mosi_sync_q <= mosi_meta_q;
    end
  end

  logic rise, fall, cs_end;
  assign rise   =  sck_sync_q & ~sck_prev_q;
  assign fall   = ~sck_sync_q &  sck_prev_q;
  assign cs_end =  csb_sync_q & ~csb_prev_q;

  // ---------------------------------------------------------------------------
  // Protocol state
  // ---------------------------------------------------------------------------
  state_e              state_q,     state_d;
  logic [2:0]          bit_cnt_q,   bit_cnt_d;
  logic [ADDR_W-2:0]   in_sh_q,     in_sh_d;
  logic [1:0]          byte_idx_q,  byte_idx_d;
  logic [ADDR_W-1:0]   addr_q,      addr_d;
  logic                mem_req_q,   mem_req_d;
  logic                pend_load_q, pend_load_d;
  logic [7:0]          pend_q,      pend_d;
  logic [7:0]          shift_q,     shift_d;
  logic                oe_q,        oe_d;
  logic [15:0]         read_cnt_q,  read_cnt_d;
  logic                busy_q,      busy_d;

  // The received word includes the bit sampled on the current rise, so a
  // completed byte or address is available in the same cycle it finishes.
  logic [ADDR_W-1:0] rx_word;
  logic [7:0]        rx_byte;
  logic              byte_done;
  logic              tx_state;
  logic [7:0]        load_byte;

  assign rx_word   = {in_sh_q, mosi_sync_q};
  assign rx_byte   = rx_word[7:0];
  assign byte_done = rise && (bit_cnt_q == 3'd7);
  assign tx_state  = (state_q == S_DATA) || (state_q == S_STATUS) ||
                     (state_q == S_ID);

  // Byte placed on MISO at each byte boundary of a transmitting state.
  always_comb begin
    load_byte = 8'h00;
    unique case (state_q)
      S_DATA:   load_byte = pend_q;
      S_STATUS: load_byte = STATUS_VAL;
      S_ID: begin
        unique case (byte_idx_q)
          2'd0:    load_byte = JEDEC_ID[23:16];
          2'd1:    load_byte = JEDEC_ID[15:8];
          2'd2:    load_byte = JEDEC_ID[7:0];
          default: load_byte = 8'h00;
        endcase
      end
      default:  load_byte = 8'h00;
    endcase
  end

  // NOTE: every signal written here gets its default at the top of the block.
  // Then no path leaves a variable unassigned, and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    in_sh_d     = in_sh_q;
    byte_idx_d  = byte_idx_q;
    addr_d      = addr_q;
    mem_req_d   = 1'b0;
    pend_load_d = mem_req_q;
    pend_d      = pend_load_q ? mem_rdata_i : pend_q;
    shift_d     = shift_q;
    oe_d        = oe_q;
    read_cnt_d  = read_cnt_q;
    busy_d      = ~csb_sync_q;

    if (cs_end) begin
      // The end of a transaction overrides any edge in the same cycle. A
      // partial byte, command or address is dropped here.
      state_d     = S_IDLE;
      bit_cnt_d   = 3'd0;
      oe_d        = 1'b0;
      mem_req_d   = 1'b0;
      pend_load_d = 1'b0;
      if (state_q == S_DATA) begin
        read_cnt_d = read_cnt_q + 16'd1;
      end
    end else begin
      if ((state_q != S_IDLE) && rise) begin
        bit_cnt_d = bit_cnt_q + 3'd1;
        in_sh_d   = rx_word[ADDR_W-2:0];
      end

      unique case (state_q)
        S_IDLE: begin
          bit_cnt_d = 3'd0;
          oe_d      = 1'b0;
          if (!csb_sync_q) begin
            state_d = S_CMD;
          end
        end

        S_CMD: begin
          if (byte_done) begin
            byte_idx_d = 2'd0;
            unique case (rx_byte)
              CMD_READ:   state_d = S_ADDR;
              CMD_STATUS: state_d = S_STATUS;
              CMD_ID:     state_d = S_ID;
              default:    state_d = S_IGNORE;
            endcase
          end
        end

        S_ADDR: begin
          if (byte_done) begin
            if (byte_idx_q == 2'd2) begin
              addr_d    = rx_word;
              mem_req_d = 1'b1;
              state_d   = S_DATA;
            end else begin
              byte_idx_d = byte_idx_q + 2'd1;
            end
          end
        end

        S_DATA: begin
          // Fetch the next byte as soon as the master has clocked in the
          // current one. That leaves half an sck period before the data is
          // needed.
          if (byte_done) begin
            addr_d    = addr_q + ADDR_W'(1);
            mem_req_d = 1'b1;
          end
        end

        default: ;
      endcase

      // MISO changes on the falling edge. A fall at bit 0 starts a new byte.
      if (tx_state && fall) begin
        oe_d = 1'b1;
        if (bit_cnt_q == 3'd0) begin
          shift_d = load_byte;
          if ((state_q == S_ID) && (byte_idx_q != 2'd3)) begin
            byte_idx_d = byte_idx_q + 2'd1;
          end
        end else begin
          shift_d = {shift_q[6:0], 1'b0};
        end
      end
    end
  end

  // NOTE: all control and datapath flops reset asynchronously. These are
  // individual registers, not a RAM array, so each one can be reset.
  always_ff @(posedge clk_gen or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      bit_cnt_q   <= 3'd0;
      in_sh_q     <= '0;
      byte_idx_q  <= 2'd0;
      addr_q      <= '0;
      mem_req_q   <= 1'b0;
      pend_load_q <= 1'b0;
      pend_q      <= 8'h00;
      shift_q     <= 8'h00;
      oe_q        <= 1'b0;
      read_cnt_q  <= 16'd0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      in_sh_q     <= in_sh_d;
      byte_idx_q  <= byte_idx_d;
      addr_q      <= addr_d;
      mem_req_q   <= mem_req_d;
      pend_load_q <= pend_load_d;
      pend_q      <= pend_d;
      shift_q     <= shift_d;
      oe_q        <= oe_d;
      read_cnt_q  <= read_cnt_d;
      busy_q      <= busy_d;
    end
  end

  assign spi_miso_o    = oe_q & shift_q[7];
  assign spi_miso_oe_o = oe_q;
  assign mem_req_o     = mem_req_q;
  assign mem_addr_o    = addr_q;
  assign busy_o        = busy_q;
  assign read_cnt_o    = read_cnt_q;

endmodule
